// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if : program-memory, decode-handshake and control bundle of the
//                 instruction fetch stage.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if #(
  parameter int CNT_W = 16
);
  typedef struct packed {
    logic [5:0] phys_addr;
  } addr_t;

  typedef struct packed {
    logic [7:0] raw_data;
  } data_t;

  logic             fetch_en;
  addr_t            mem_addr;
  data_t            mem_data;
  logic             inst_valid;
  logic             inst_ready;
  logic [7:0]       inst_data;
  logic [5:0]       inst_pc;
  logic             redirect_valid;
  logic [5:0]       redirect_pc;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  fetch_en, mem_data, inst_ready, redirect_valid, redirect_pc,
    output mem_addr, inst_valid, inst_data, inst_pc, fetch_count
  );

  modport slave (
    output fetch_en, mem_data, inst_ready, redirect_valid, redirect_pc,
    input  mem_addr, inst_valid, inst_data, inst_pc, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : PC owner, byte fetch into a small queue, valid/ready hand-off
//              to decode, redirect flush and fetch-enable gate.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [5:0] RESET_PC = 6'd0,
  parameter int         CNT_W    = 16   // must match the interface CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [5:0]       pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [7:0]       dat_q [DEPTH];
  logic [5:0]       ipc_q [DEPTH];

  logic valid_w, pop_w, push_w;

  assign valid_w = (cnt_q != '0);
  assign pop_w   = valid_w & bus.inst_ready;
  // A full queue still takes a byte when the head leaves in the same cycle.
  assign push_w  = (state_q == RUN) & bus.fetch_en & ~bus.redirect_valid &
                   ((cnt_q < CW'(DEPTH)) | pop_w);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      IDLE:    if (bus.fetch_en)  state_d = RUN;
      RUN:     if (!bus.fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.redirect_valid) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      pc_d  = bus.redirect_pc;
    end else begin
      if (push_w) begin
        wr_d = wr_q + 1'b1;
        pc_d = pc_q + 6'd1;
      end
      if (pop_w) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_w) - CW'(pop_w);
    end

    if (push_w && (fcnt_q != '1)) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        ipc_q[i] <= '0;
      end
    end else if (push_w) begin
      dat_q[wr_q] <= bus.mem_data.raw_data;
      ipc_q[wr_q] <= pc_q;
    end
  end

  assign bus.mem_addr.phys_addr = pc_q;
  assign bus.inst_valid         = valid_w;
  assign bus.inst_data          = valid_w ? dat_q[rd_q] : 8'd0;
  assign bus.inst_pc            = valid_w ? ipc_q[rd_q] : 6'd0;
  assign bus.fetch_count        = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed bench for fetch_unit with a 64-byte program memory
//                 holding mem[i] = 8'h10 + 8'h11*i.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] mem [64];

  fetch_unit_if #(.CNT_W(16)) bus ();

  fetch_unit #(
    .DEPTH    (2),
    .RESET_PC (6'd0),
    .CNT_W    (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.mem_data = mem[bus.mem_addr.phys_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [7:0] d, input logic [5:0] p);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'(v));
    chk({tag, "_data"},  32'(bus.inst_data),  32'(d));
    chk({tag, "_pc"},    32'(bus.inst_pc),    32'(p));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(16 + 17 * i);

    rst_n              = 1'b0;
    bus.fetch_en       = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 6'd0;

    // Reset state
    step();
    step();
    chk_head("rst", 1'b0, 8'h00, 6'd0);
    chk("rst_addr",  32'(bus.mem_addr.phys_addr), 32'd0);
    chk("rst_fcnt",  32'(bus.fetch_count),        32'd0);

    // Release: one IDLE->RUN cycle, then streaming
    rst_n = 1'b1;
    step();
    chk_head("idle2run", 1'b0, 8'h00, 6'd0);
    chk("idle2run_addr", 32'(bus.mem_addr.phys_addr), 32'd0);
    step(); chk_head("s0", 1'b1, 8'h10, 6'd0);
    chk("s0_addr", 32'(bus.mem_addr.phys_addr), 32'd1);
    step(); chk_head("s1", 1'b1, 8'h21, 6'd1);
    step(); chk_head("s2", 1'b1, 8'h32, 6'd2);
    step(); chk_head("s3", 1'b1, 8'h43, 6'd3);
    chk("s3_fcnt", 32'(bus.fetch_count), 32'd4);
    chk("s3_addr", 32'(bus.mem_addr.phys_addr), 32'd4);

    // Back-pressure: fills to DEPTH, head held, pc stalls
    bus.inst_ready = 1'b0;
    step(); chk_head("bp0", 1'b1, 8'h43, 6'd3);
    chk("bp0_addr", 32'(bus.mem_addr.phys_addr), 32'd5);
    step(); chk_head("bp1", 1'b1, 8'h43, 6'd3);
    chk("bp1_addr", 32'(bus.mem_addr.phys_addr), 32'd5);
    chk("bp1_fcnt", 32'(bus.fetch_count), 32'd5);

    // Full queue with pop accepts a push in the same cycle
    bus.inst_ready = 1'b1;
    step(); chk_head("fullpop", 1'b1, 8'h54, 6'd4);
    chk("fullpop_addr", 32'(bus.mem_addr.phys_addr), 32'd6);
    chk("fullpop_fcnt", 32'(bus.fetch_count), 32'd6);
    step(); chk_head("head5", 1'b1, 8'h65, 6'd5);

    // Redirect to 40 while full (head @5)
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 6'd40;
    step(); chk_head("redir", 1'b0, 8'h00, 6'd0);
    chk("redir_addr", 32'(bus.mem_addr.phys_addr), 32'd40);
    chk("redir_fcnt", 32'(bus.fetch_count), 32'd7);
    bus.redirect_valid = 1'b0;
    step(); chk_head("redir_t", 1'b1, 8'hB8, 6'd40);
    chk("redir_t_fcnt", 32'(bus.fetch_count), 32'd8);

    // Redirect with simultaneous pop, then PC wrap 62,63,0,1
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 6'd62;
    step(); chk_head("redir62", 1'b0, 8'h00, 6'd0);
    chk("redir62_addr", 32'(bus.mem_addr.phys_addr), 32'd62);
    bus.redirect_valid = 1'b0;
    step(); chk_head("w62", 1'b1, 8'h2E, 6'd62);
    step(); chk_head("w63", 1'b1, 8'h3F, 6'd63);
    chk("w63_addr", 32'(bus.mem_addr.phys_addr), 32'd0);
    step(); chk_head("w0", 1'b1, 8'h10, 6'd0);
    step(); chk_head("w1", 1'b1, 8'h21, 6'd1);
    chk("w1_fcnt", 32'(bus.fetch_count), 32'd12);

    // fetch_en low for 3 cycles: pc held, queue drains
    bus.fetch_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_head("hold", 1'b0, 8'h00, 6'd0);
      chk("hold_addr", 32'(bus.mem_addr.phys_addr), 32'd2);
    end
    chk("hold_fcnt", 32'(bus.fetch_count), 32'd12);
    bus.fetch_en = 1'b1;
    step(); chk_head("reen_idle", 1'b0, 8'h00, 6'd0);
    chk("reen_idle_addr", 32'(bus.mem_addr.phys_addr), 32'd2);
    step(); chk_head("reen", 1'b1, 8'h32, 6'd2);
    chk("reen_fcnt", 32'(bus.fetch_count), 32'd13);

    // Redirect while fetch is disabled still moves pc and flushes
    bus.fetch_en       = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 6'd10;
    step(); chk_head("redir_dis", 1'b0, 8'h00, 6'd0);
    chk("redir_dis_addr", 32'(bus.mem_addr.phys_addr), 32'd10);
    bus.redirect_valid = 1'b0;
    step(); chk_head("dis_idle", 1'b0, 8'h00, 6'd0);

    // Fill two entries, then assert reset mid-cycle
    bus.fetch_en = 1'b1;
    step(); chk_head("f_idle", 1'b0, 8'h00, 6'd0);
    step(); chk_head("f0", 1'b1, 8'hBA, 6'd10);
    step(); chk_head("f1", 1'b1, 8'hBA, 6'd10);
    chk("f1_addr", 32'(bus.mem_addr.phys_addr), 32'd12);
    chk("f1_fcnt", 32'(bus.fetch_count), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk_head("arst", 1'b0, 8'h00, 6'd0);
    chk("arst_addr", 32'(bus.mem_addr.phys_addr), 32'd0);
    chk("arst_fcnt", 32'(bus.fetch_count), 32'd0);
    step();
    rst_n          = 1'b1;
    bus.inst_ready = 1'b1;
    step(); chk_head("post_idle", 1'b0, 8'h00, 6'd0);
    step(); chk_head("post0", 1'b1, 8'h10, 6'd0);
    chk("post0_fcnt", 32'(bus.fetch_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
